// File: rtl/seg7_pattern_monitor.sv
// seg7_pattern_monitor
//
// Watches the active-low seven-segment lines {a,b,c,d,e,f,g} that a segment
// decoder drives. It recovers the displayed digit once the pattern has stayed
// the same for STABLE_CYCLES consecutive samples, flags blank and illegal
// patterns, and counts how often the published result changes.
//
// Parameters:
//   STABLE_CYCLES  consecutive identical samples needed to publish (1..255)
//   CNT_W          width of the update counter
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous, active-high reset
//   a..g       segment lines, active-low; a is the MSB of the pattern
//   digit      last published legal digit value
//   valid      published pattern is a legal digit
//   blank      published pattern is all-off (7'b1111111)
//   err        published pattern is neither legal nor blank
//   update     one-cycle pulse when the published result changes
//   upd_count  number of update pulses since reset, wraps
//
// Build option:
//   SEG7_MON_HEX_EN  when defined, the hex glyphs A,b,C,d,E,F are legal and
//                    publish digit values 10..15.

module seg7_pattern_monitor #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  input  logic             d,
  input  logic             e,
  input  logic             f,
  input  logic             g,
  output logic [3:0]       digit,
  output logic             valid,
  output logic             blank,
  output logic             err,
  output logic             update,
  output logic [CNT_W-1:0] upd_count
);

  localparam logic [6:0] BLANK_PAT = 7'b1111111;
  // Count value at which the candidate has been seen STABLE_CYCLES times.
  localparam logic [7:0] PUB_AT    = 8'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  // Returns {legal, value} for a segment pattern.
  function automatic logic [4:0] decode(input logic [6:0] pat);
    logic [4:0] res;
    case (pat)
      7'b0000001: res = {1'b1, 4'd0};
      7'b1001111: res = {1'b1, 4'd1};
      7'b0010010: res = {1'b1, 4'd2};
      7'b0000110: res = {1'b1, 4'd3};
      7'b1001100: res = {1'b1, 4'd4};
      7'b0100100: res = {1'b1, 4'd5};
      7'b0100000: res = {1'b1, 4'd6};
      7'b0001111: res = {1'b1, 4'd7};
      7'b0000000: res = {1'b1, 4'd8};
      7'b0000100: res = {1'b1, 4'd9};
`ifdef SEG7_MON_HEX_EN
      7'b0001000: res = {1'b1, 4'd10};
      7'b1100000: res = {1'b1, 4'd11};
      7'b0110001: res = {1'b1, 4'd12};
      7'b1000010: res = {1'b1, 4'd13};
      7'b0110000: res = {1'b1, 4'd14};
      7'b0111000: res = {1'b1, 4'd15};
`endif
      default:    res = {1'b0, 4'd0};
    endcase
    return res;
  endfunction

  logic [6:0] samp_r;
  logic [6:0] cand_r;
  logic [6:0] pub_r;
  logic [7:0] stab_cnt_r;
  state_t     state_r;
  logic       pub_seen_r;   // at least one publish since reset

  logic [6:0] cand_s;
  logic [7:0] stab_cnt_s;
  state_t     state_s;
  logic       do_pub_s;
  logic       changed_s;
  logic [4:0] dec_s;

  // Next-state logic: candidate tracking, stability count and publish strobe.
  always_comb begin
    cand_s     = cand_r;
    stab_cnt_s = stab_cnt_r;
    state_s    = state_r;
    do_pub_s   = 1'b0;
    if (samp_r != cand_r) begin
      // A new pattern restarts the count; this sample is its first sighting,
      // so with STABLE_CYCLES == 1 it is already stable enough to publish.
      cand_s     = samp_r;
      stab_cnt_s = 8'd0;
      if (PUB_AT == 8'd0) begin
        do_pub_s = 1'b1;
        state_s  = LOCKED;
      end else begin
        state_s  = TRACK;
      end
    end else begin
      case (state_r)
        IDLE: begin
          state_s = IDLE;
        end
        TRACK: begin
          stab_cnt_s = stab_cnt_r + 8'd1;
          if (stab_cnt_r + 8'd1 == PUB_AT) begin
            do_pub_s = 1'b1;
            state_s  = LOCKED;
          end else begin
            state_s  = TRACK;
          end
        end
        LOCKED: begin
          state_s = LOCKED;
        end
        default: begin
          state_s = IDLE;
        end
      endcase
    end
  end

  // Classification of the pattern being published and whether it is news.
  always_comb begin
    dec_s     = decode(samp_r);
    changed_s = !pub_seen_r || (samp_r != pub_r);
  end

  // State registers and registered outputs; reset overrides any publish.
  always_ff @(posedge clk) begin
    if (reset) begin
      samp_r     <= BLANK_PAT;
      cand_r     <= BLANK_PAT;
      pub_r      <= BLANK_PAT;
      stab_cnt_r <= 8'd0;
      state_r    <= IDLE;
      pub_seen_r <= 1'b0;
      digit      <= 4'd0;
      valid      <= 1'b0;
      blank      <= 1'b0;
      err        <= 1'b0;
      update     <= 1'b0;
      upd_count  <= '0;
    end else begin
      samp_r     <= {a, b, c, d, e, f, g};
      cand_r     <= cand_s;
      stab_cnt_r <= stab_cnt_s;
      state_r    <= state_s;
      if (do_pub_s) begin
        // The published pattern equals samp_r, which equals the candidate.
        pub_r      <= samp_r;
        pub_seen_r <= 1'b1;
        if (dec_s[4]) begin
          digit <= dec_s[3:0];
          valid <= 1'b1;
          blank <= 1'b0;
          err   <= 1'b0;
        end else if (samp_r == BLANK_PAT) begin
          valid <= 1'b0;
          blank <= 1'b1;
          err   <= 1'b0;
        end else begin
          valid <= 1'b0;
          blank <= 1'b0;
          err   <= 1'b1;
        end
        update <= changed_s;
        if (changed_s) begin
          upd_count <= upd_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          upd_count <= upd_count;
        end
      end else begin
        update <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seg7_pattern_monitor.sv
// Testbench for seg7_pattern_monitor (STABLE_CYCLES=4, CNT_W=8).
// A run-length reference model predicts each change of the published result;
// predictions are queued and a monitor pops one on every update pulse.
module tb_seg7_pattern_monitor;

  localparam int S = 4;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [6:0]   seg = 7'b1111111;
  logic [3:0]   digit;
  logic         valid, blank, err, update;
  logic [W-1:0] upd_count;

  seg7_pattern_monitor #(.STABLE_CYCLES(S), .CNT_W(W)) dut (
    .clk(clk), .reset(reset),
    .a(seg[6]), .b(seg[5]), .c(seg[4]), .d(seg[3]),
    .e(seg[2]), .f(seg[1]), .g(seg[0]),
    .digit(digit), .valid(valid), .blank(blank), .err(err),
    .update(update), .upd_count(upd_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Glyph table: index = displayed value.
  logic [6:0] glyph [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                             7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                             7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                             7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
`ifdef SEG7_MON_HEX_EN
  localparam int NLEGAL = 16;
`else
  localparam int NLEGAL = 10;
`endif

  typedef struct {
    int         cyc;
    logic [3:0] digit;
    logic       valid, blank, err;
    logic [7:0] cnt;
  } exp_t;
  exp_t q[$];

  int n_vec = 0;
  int n_bad = 0;

  // Reference model state: run of identical samples seen since reset.
  logic [6:0] m_run_val;
  bit         m_counting;
  int         m_run_len;
  bit         m_pend;
  logic [6:0] m_pend_val;
  bit         m_first;
  logic [6:0] m_last_pub;
  logic [3:0] m_digit;
  logic       m_valid, m_blank, m_err;
  int         m_cnt;

  function automatic int lookup(input logic [6:0] p);
    for (int i = 0; i < NLEGAL; i++) if (glyph[i] == p) return i;
    return -1;
  endfunction

  task automatic chk(input string nm, input int act, input int expv);
    n_vec++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  task automatic model_publish(input logic [6:0] v, input int at);
    int idx;
    idx = lookup(v);
    m_valid = (idx >= 0);
    m_blank = (idx < 0) && (v == 7'b1111111);
    m_err   = (idx < 0) && (v != 7'b1111111);
    if (idx >= 0) m_digit = 4'(idx);
    if (m_first || v != m_last_pub) begin
      m_cnt++;
      q.push_back('{at, m_digit, m_valid, m_blank, m_err, 8'(m_cnt)});
    end
    m_first    = 1'b0;
    m_last_pub = v;
  endtask

  // Apply one sample/reset for the next edge, advance the model, wait it out.
  task automatic step(input logic [6:0] pat, input logic r);
    if (!r && m_pend) model_publish(m_pend_val, cyc + 1);
    m_pend = 1'b0;
    if (r) begin
      m_run_val = 7'b1111111; m_counting = 1'b0; m_run_len = 0;
      m_first = 1'b1; m_last_pub = 7'b1111111; m_cnt = 0;
      m_digit = 4'd0; m_valid = 1'b0; m_blank = 1'b0; m_err = 1'b0;
    end else begin
      if (pat == m_run_val) begin
        if (m_counting) m_run_len++;
      end else begin
        m_run_val = pat; m_counting = 1'b1; m_run_len = 1;
      end
      if (m_counting && m_run_len == S) begin
        m_pend = 1'b1; m_pend_val = pat;
      end
    end
    seg = pat;
    reset = r;
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input logic [6:0] pat, input int n);
    for (int i = 0; i < n; i++) step(pat, 1'b0);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, " digit"}, digit, 0);
    chk({nm, " valid"}, valid, 0);
    chk({nm, " blank"}, blank, 0);
    chk({nm, " err"}, err, 0);
    chk({nm, " update"}, update, 0);
    chk({nm, " upd_count"}, upd_count, 0);
  endtask

  initial begin
    fork
      // Monitor: every update pulse must match the oldest queued prediction.
      forever begin
        @(negedge clk);
        while (q.size() > 0 && q[0].cyc < cyc) begin
          n_vec++; n_bad++;
          $display("FAIL missed update: got none, expected pulse at cycle %0d", q[0].cyc);
          void'(q.pop_front());
        end
        if (update === 1'b1) begin
          if (q.size() == 0) begin
            n_vec++; n_bad++;
            $display("FAIL spurious update: got pulse at cycle %0d, expected none", cyc);
          end else begin
            exp_t ex;
            ex = q.pop_front();
            chk("update cycle", cyc, ex.cyc);
            chk("digit", digit, ex.digit);
            chk("valid", valid, ex.valid);
            chk("blank", blank, ex.blank);
            chk("err", err, ex.err);
            chk("upd_count", upd_count, ex.cnt);
          end
        end
      end
    join_none

    step(7'b1111111, 1'b1);
    step(7'b1111111, 1'b1);
    chk_zero("reset");

    // Digit 2 held: publishes S edges after capture.
    hold(7'b0010010, 7);
    chk("first publish digit", digit, 2);
    chk("first publish upd_count", upd_count, 1);
    // Short glitch of 4 then back to 2: nothing new is published.
    hold(7'b1001100, 3);
    hold(7'b0010010, 6);
    chk("glitch digit", digit, 2);
    chk("glitch upd_count", upd_count, 1);
    hold(7'b1111111, 6);
    chk("blank flag", blank, 1);
    chk("blank digit holds", digit, 2);
    hold(7'b1111110, 6);
    chk("illegal err", err, 1);
    chk("illegal upd_count", upd_count, 3);
    hold(7'b0001000, 6);
`ifdef SEG7_MON_HEX_EN
    chk("hex A digit", digit, 10);
    chk("hex A valid", valid, 1);
`else
    chk("hex A err", err, 1);
    chk("hex A digit holds", digit, 2);
`endif
    // Reset lands on the edge that would publish 9.
    hold(7'b0000100, 4);
    step(7'b0000100, 1'b1);
    chk_zero("reset over publish");
    hold(7'b0000100, 7);
    chk("post-reset digit 9", digit, 9);

    // Blank held across reset is not published until something else is seen.
    step(7'b1111111, 1'b1);
    hold(7'b1111111, 8);
    chk("blank across reset", blank, 0);

    // Counter wrap: alternate 0 and 1, 300 times each.
    for (int i = 0; i < 300; i++) begin
      hold(glyph[0], 4);
      hold(glyph[1], 4);
    end

    // Random segments with random hold lengths and occasional resets.
    for (int i = 0; i < 700; i++) begin
      logic [6:0] p;
      int k;
      k = $urandom_range(0, 9);
      if (k <= 5)      p = glyph[$urandom_range(0, 9)];
      else if (k == 6) p = 7'b1111111;
      else if (k == 7) p = glyph[$urandom_range(10, 15)];
      else             p = 7'($urandom_range(0, 127));
      if ($urandom_range(0, 39) == 0) step(p, 1'b1);
      hold(p, $urandom_range(1, 7));
    end

    hold(seg, 10);
    chk("scoreboard drained", q.size(), 0);
    chk("final digit", digit, m_digit);
    chk("final valid", valid, m_valid);
    chk("final blank", blank, m_blank);
    chk("final err", err, m_err);
    chk("final upd_count", upd_count, m_cnt % 256);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/seg7_pattern_monitor.md
Name: seg7_pattern_monitor

Overview:
- Reader side of the team's seven-segment interface: watches the active-low segment lines {a,b,c,d,e,f,g} that the segment decoders drive.
- Recovers the displayed digit after the pattern has been stable for a programmable number of cycles.
- Flags blank and illegal patterns, and counts display changes.
- Used as an on-chip checker and scoreboard source for display paths.

Parameters:
- STABLE_CYCLES, 4, consecutive identical samples required before a pattern is published (legal range 1..255).
- CNT_W, 8, width of the update counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- a,b,c,d,e,f,g  input  1 each  segment lines, active-low (0 = lit); a is the MSB of the pattern {a,b,c,d,e,f,g}.
- digit  output  4  last published legal digit value.
- valid  output  1  published pattern is a legal digit.
- blank  output  1  published pattern is all-off, 7'b1111111.
- err  output  1  published pattern is neither legal nor blank.
- update  output  1  one-cycle pulse when the published result changes.
- upd_count  output  CNT_W  number of update pulses since reset; wraps.

Behaviour:
- Segment inputs are registered into samp every cycle; all logic works on samp.
- Legal patterns {a..g}:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
  - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100
- Internal state: cand (7b), stab_cnt (8b), pub (7b).
- FSM states:
  - IDLE: after reset; nothing published yet.
  - TRACK: candidate is counting toward stability.
  - LOCKED: cand equals pub.
- Every cycle:
  - If samp != cand: cand<=samp, stab_cnt<=0, state<=TRACK. Any earlier count is discarded.
  - Else, in TRACK: stab_cnt increments. When stab_cnt reaches STABLE_CYCLES-1, cand is published: pub<=cand, outputs update, state<=LOCKED.
  - In LOCKED with samp==cand: hold, no counting.
- Publish rules:
  - Legal digit: digit<=value, valid=1, blank=0, err=0.
  - Blank: valid=0, blank=1, err=0; digit holds.
  - Other: valid=0, err=1, blank=0; digit holds.
- update pulses high for exactly the cycle after a publish, and only if the new pub differs from the previous pub (or on the first publish after reset). upd_count increments on the same edge; it wraps from 2^CNT_W-1 to 0.
- Latency: if the segment inputs are held from before edge E0, samp captures at E0 and the outputs change at edge E0+STABLE_CYCLES. With STABLE_CYCLES=1 this is one edge after sampling.
- Glitches: a pattern held for fewer than STABLE_CYCLES samples is never published. Outputs keep their previous values.
- Reset (synchronous, wins over all other activity, including a publish on the same edge):
  - digit=0, valid=0, blank=0, err=0, update=0, upd_count=0.
  - samp=cand=pub=7'b1111111, stab_cnt=0, state=IDLE.
  - Asserting reset mid-count drops the candidate.
  - In IDLE, samp==cand does not count. The first differing sample enters TRACK.
  - A blank held across reset is therefore not published until a non-blank pattern has been seen.

Optional Feature:
- Macro SEG7_MON_HEX_EN.
- Defined: hex patterns A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000 are legal. They publish digit=10..15 with valid=1.
- Undefined: those patterns set err=1, valid=0, and digit holds.
- No other behaviour differs.

Test Plan:
- Reset, then drive 0010010 (2) continuously with STABLE_CYCLES=4 -> digit=2, valid=1 exactly 4 edges after samp captures; update pulses once; upd_count=1.
- Hold 2, then drive 1001100 (4) for 3 cycles, then back to 2 -> no update pulse, digit stays 2, upd_count stays 1.
- From 2, drive 1111111 stable -> blank=1, valid=0, digit stays 2, upd_count=2. Then drive 1111110 stable -> err=1, blank=0, upd_count=3.
- Drive 0001000 stable -> with SEG7_MON_HEX_EN: digit=10, valid=1. Without it: err=1, digit unchanged.
- Assert reset on the edge where a publish of 9 (0000100) would occur -> all outputs zero. Keep 0000100 after reset: it stays in IDLE (samp matches the reset cand? no, it differs), enters TRACK, and publishes 9 STABLE_CYCLES edges later.
- CNT_W=2: alternate 0 and 1 patterns, each held for 4 cycles, through 5 publishes -> upd_count sequence 1,2,3,0,1.
